// File: rtl/fsm_arb_pkg.sv
// ============================================================================
// Module      : fsm_arb_pkg
// Description : State encoding shared by the round-robin arbiter FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARB     = 2'b01;
    localparam logic [1:0] ST_GRANT   = 2'b10;
    localparam logic [1:0] ST_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_ARB     = ST_ARB,
        S_GRANT   = ST_GRANT,
        S_RELEASE = ST_RELEASE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, scans upward from last_id+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    output logic             valid,
    output logic [IDW-1:0]   index
);

    // Walk the offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[IDW'((int'(last_id) + i) % N_REQ)]) begin
                valid = 1'b1;
                index = IDW'((int'(last_id) + i) % N_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_fsm.sv
// ============================================================================
// Module      : rr_arbiter_fsm
// Description : Moore round-robin arbiter FSM (IDLE/ARB/GRANT/RELEASE).
//               Define ARB_TIMEOUT_EN to force release after MAX_GRANT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_fsm #(
    parameter int N_REQ     = 4,
    parameter int MAX_GRANT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic [1:0]               p_state,
    output logic                     timeout
);

    import fsm_arb_pkg::*;

    localparam int IDW = $clog2(N_REQ);

    state_t         state_q, state_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           rel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    // Only the current grantee's lines can end a grant.
    assign rel = done[gnt_id_q] | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_GRANT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q;
    logic          expire;

    assign expire = (cnt_q == CW'(MAX_GRANT - 1));
    assign cnt_d  = (state_q == S_GRANT) ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= (state_q == S_GRANT) && expire && !rel;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_GRANT > 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                if (pick_valid) begin
                    state_d  = S_GRANT;
                    gnt_id_d = pick_idx;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_GRANT: begin
                if (rel) state_d = S_RELEASE;
`ifdef ARB_TIMEOUT_EN
                else if (expire) state_d = S_RELEASE;
`endif
            end
            S_RELEASE: begin
                last_id_d = gnt_id_q;
                state_d   = (|req) ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_id_q  <= '0;
            last_id_q <= IDW'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == S_GRANT) gnt[gnt_id_q] = 1'b1;
    end

    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q != S_IDLE);
    assign p_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
// ============================================================================
// Module      : tb_rr_arbiter_fsm
// Description : Self-checking bench for rr_arbiter_fsm with a reference model.
//               Honours ARB_TIMEOUT_EN to select the timeout or hold scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_fsm;

    localparam int N    = 4;
    localparam int MAXG = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] p_state;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rr_arbiter_fsm #(.N_REQ(N), .MAX_GRANT(MAXG)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .p_state (p_state),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 arbitrate, 2 granted, 3 release gap.
    int m_mode, m_owner, m_last, m_held, m_to;

    function automatic int rr_next(input int last, input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  <= 0;
            m_owner <= 0;
            m_last  <= N - 1;
            m_held  <= 0;
            m_to    <= 0;
        end else begin
            m_to <= 0;
            case (m_mode)
                0: if (req != 4'b0) m_mode <= 1;
                1: begin
                    if (rr_next(m_last, req) >= 0) begin
                        m_mode  <= 2;
                        m_owner <= rr_next(m_last, req);
                        m_held  <= 1;
                    end else begin
                        m_mode <= 0;
                    end
                end
                2: begin
                    m_held <= m_held + 1;
                    if (done[m_owner] || !req[m_owner]) m_mode <= 3;
                    else if (TO_EN && m_held >= MAXG) begin
                        m_mode <= 3;
                        m_to   <= 1;
                    end
                end
                default: begin
                    m_last <= m_owner;
                    m_mode <= (req != 4'b0) ? 1 : 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("gnt",     int'(gnt),     (m_mode == 2) ? (1 << m_owner) : 0);
        chk("gnt_id",  int'(gnt_id),  m_owner);
        chk("busy",    int'(busy),    (m_mode != 0) ? 1 : 0);
        chk("p_state", int'(p_state), m_mode);
        chk("timeout", int'(timeout), m_to);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string nm);
        int n;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, (gnt != 4'b0) ? 1 : 0, 1);
    endtask

    int ids[5];
    int ts[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n_hi;

    initial begin
        rst  = 1'b0;
        req  = 4'b1111;
        done = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_pstate", int'(p_state), 0);
        rst = 1'b1;
        tick();
        chk("lat_arb", int'(p_state), 1);
        chk("lat_gnt_low", int'(gnt), 0);
        tick();
        chk("lat_gnt", int'(gnt), 1);

        // Rotation with every grantee releasing immediately
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rot_wait");
            ids[k] = int'(gnt_id);
            ts[k]  = cyc;
            done   = gnt;
            tick();
            done   = 4'b0000;
        end
        for (int k = 0; k < 5; k++) chk("rot_order", ids[k], exp_order[k]);
        // one grant cycle plus the two-cycle gap
        for (int k = 1; k < 5; k++) chk("rot_gap", ts[k] - ts[k-1], 3);

        req = 4'b0000;
        repeat (3) tick();
        chk("idle", int'(p_state), 0);

        // Request withdrawn while arbitrating
        req = 4'b0100;
        tick();
        chk("wd_arb", int'(p_state), 1);
        req = 4'b0000;
        tick();
        chk("wd_idle", int'(p_state), 0);
        for (int k = 0; k < 4; k++) begin
            chk("wd_nognt", int'(gnt), 0);
            tick();
        end

        // Skip over idle requesters
        req = 4'b1010;
        wait_gnt("skip_w1");
        chk("skip_first", int'(gnt_id), 1);
        chk("skip_first_gnt", int'(gnt), 4'b0010);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        wait_gnt("skip_w2");
        chk("skip_second", int'(gnt_id), 3);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        chk("ignore_done", int'(gnt), 4'b1000);
        done = 4'b1000;
        tick();
        done = 4'b0000;
        wait_gnt("skip_w3");
        chk("skip_third", int'(gnt_id), 1);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        repeat (3) tick();

        // Reset in the middle of a grant
        req = 4'b0100;
        wait_gnt("mr_wait");
        chk("mr_owner", int'(gnt_id), 2);
        #2 rst = 1'b0;
        #1;
        chk("mr_gnt", int'(gnt), 0);
        chk("mr_pstate", int'(p_state), 0);
        chk("mr_id", int'(gnt_id), 0);
        chk("mr_busy", int'(busy), 0);
        req = 4'b0101;
        @(posedge clk);
        #3 rst = 1'b1;
        wait_gnt("mr_regrant");
        chk("mr_first", int'(gnt_id), 0);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        repeat (3) tick();

`ifdef ARB_TIMEOUT_EN
        req = 4'b0001;
        wait_gnt("to_wait");
        n_hi = 0;
        while (gnt != 4'b0 && n_hi < 20) begin
            n_hi++;
            tick();
        end
        chk("to_len", n_hi, 8);
        chk("to_pulse", int'(timeout), 1);
        tick();
        chk("to_once", int'(timeout), 0);
        wait_gnt("to_wait2");
        repeat (7) tick();
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk("exp_done_gnt", int'(gnt), 0);
        chk("exp_done_to", int'(timeout), 0);
`else
        req = 4'b0001;
        wait_gnt("hold_wait");
        for (int k = 0; k < 100; k++) begin
            chk("hold_gnt", int'(gnt), 1);
            chk("hold_to", int'(timeout), 0);
            tick();
        end
        n_hi = 0;
`endif
        req  = 4'b0000;
        done = 4'b0000;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
